// File: rtl/dram_cmd_arbiter.sv
// Round-robin DRAM command arbiter: grants one timing-legal bank request per cycle
// and drives the granted bank's command onto the registered DRAM command/address bus.
module dram_cmd_arbiter #(
    parameter int unsigned ADDR_BITS = 14,
    parameter int unsigned TRCD      = 3,
    parameter int unsigned TRP       = 3,
    parameter int unsigned TRRD      = 2,
    parameter int unsigned TCCD      = 2,
    parameter int unsigned TWTR      = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   init_done,
    input  logic [7:0]             req,
    input  logic [15:0]            req_cmd,
    input  logic [7:0]             issue,
    input  logic [8*ADDR_BITS-1:0] issue_addr,
    output logic [7:0]             stall,
    output logic                   cs_n,
    output logic                   ras_n,
    output logic                   cas_n,
    output logic                   we_n,
    output logic [2:0]             ba,
    output logic [ADDR_BITS-1:0]   a,
    output logic                   err
);
    localparam int unsigned NB = 8;
    localparam int unsigned TW = 4;

    localparam logic [TW-1:0] TRCD_LD = TW'(TRCD - 1);
    localparam logic [TW-1:0] TRP_LD  = TW'(TRP - 1);
    localparam logic [TW-1:0] TRRD_LD = TW'(TRRD - 1);
    localparam logic [TW-1:0] TCCD_LD = TW'(TCCD - 1);
    localparam logic [TW-1:0] TWTR_LD = TW'(TWTR - 1);

    typedef enum logic [1:0] {
        CMD_ACT = 2'b00,
        CMD_RD  = 2'b01,
        CMD_WR  = 2'b10,
        CMD_PRE = 2'b11
    } cmd_e;

    typedef struct packed {
        logic [2:0] bank;
        cmd_e       cmd;
    } grant_t;

    logic [TW-1:0] rcd_q [NB];
    logic [TW-1:0] rp_q  [NB];
    logic [TW-1:0] rrd_q;
    logic [TW-1:0] ccd_q;
    logic [TW-1:0] wtr_q;
    logic [2:0]    rr_ptr_q;
    grant_t        grant_q;
    logic          grant_vld_q;

    logic [NB-1:0] elig_c;
    logic          gnt_c;
    logic [2:0]    gnt_bank_c;
    cmd_e          gnt_cmd_c;
    logic [7:0]    issue_exp_c;
    logic          issue_ok_c;
    logic          issue_err_c;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
        return (t == '0) ? t : t - TW'(1);
    endfunction

    // Per-bank timing eligibility of the requested command
    always_comb begin
        elig_c = '0;
        for (int i = 0; i < NB; i++) begin
            case (req_cmd[2*i +: 2])
                CMD_ACT: elig_c[i] = req[i] & init_done & (rp_q[i] == '0) & (rrd_q == '0);
                CMD_RD:  elig_c[i] = req[i] & init_done & (rcd_q[i] == '0) & (ccd_q == '0)
                                     & (wtr_q == '0);
                CMD_WR:  elig_c[i] = req[i] & init_done & (rcd_q[i] == '0) & (ccd_q == '0);
                default: elig_c[i] = req[i] & init_done;
            endcase
        end
    end

    // Round-robin pick starting at rr_ptr; the 3-bit index wraps naturally
    always_comb begin
        gnt_c      = 1'b0;
        gnt_bank_c = '0;
        for (int k = 0; k < NB; k++) begin
            if (!gnt_c && elig_c[rr_ptr_q + 3'(k)]) begin
                gnt_c      = 1'b1;
                gnt_bank_c = rr_ptr_q + 3'(k);
            end
        end
        gnt_cmd_c = cmd_e'(req_cmd[{gnt_bank_c, 1'b0} +: 2]);
        stall     = gnt_c ? ~(8'b1 << gnt_bank_c) : 8'hFF;
    end

    // Timers, round-robin pointer and the grant handed to the issue stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NB; i++) begin
                rcd_q[i] <= '0;
                rp_q[i]  <= '0;
            end
            rrd_q       <= '0;
            ccd_q       <= '0;
            wtr_q       <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            grant_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < NB; i++) begin
                rcd_q[i] <= dec(rcd_q[i]);
                rp_q[i]  <= dec(rp_q[i]);
            end
            rrd_q       <= dec(rrd_q);
            ccd_q       <= dec(ccd_q);
            wtr_q       <= dec(wtr_q);
            grant_vld_q <= gnt_c;
            if (gnt_c) begin
                rr_ptr_q <= gnt_bank_c + 3'd1;
                grant_q  <= '{bank: gnt_bank_c, cmd: gnt_cmd_c};
                case (gnt_cmd_c)
                    CMD_ACT: begin
                        rcd_q[gnt_bank_c] <= TRCD_LD;
                        rrd_q             <= TRRD_LD;
                    end
                    CMD_RD:  ccd_q <= TCCD_LD;
                    CMD_WR: begin
                        ccd_q <= TCCD_LD;
                        wtr_q <= TWTR_LD;
                    end
                    default: rp_q[gnt_bank_c] <= TRP_LD;
                endcase
            end
        end
    end

    // A legal issue is exactly the one-hot of last cycle's grant
    always_comb begin
        issue_exp_c = grant_vld_q ? (8'b1 << grant_q.bank) : 8'h00;
        issue_ok_c  = grant_vld_q && (issue == issue_exp_c);
        issue_err_c = grant_vld_q ? !issue_ok_c : (issue != 8'h00);
    end

    // Registered DRAM command/address pins; NOP whenever no legal issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {cs_n, ras_n, cas_n, we_n} <= 4'b1111;
            ba                         <= '0;
            a                          <= '0;
            err                        <= 1'b0;
        end else begin
            err <= err | issue_err_c;
            if (issue_ok_c) begin
                ba <= grant_q.bank;
                a  <= (grant_q.cmd == CMD_PRE) ? '0
                      : issue_addr[grant_q.bank*ADDR_BITS +: ADDR_BITS];
                case (grant_q.cmd)
                    CMD_ACT: {cs_n, ras_n, cas_n, we_n} <= 4'b0011;
                    CMD_RD:  {cs_n, ras_n, cas_n, we_n} <= 4'b0101;
                    CMD_WR:  {cs_n, ras_n, cas_n, we_n} <= 4'b0100;
                    default: {cs_n, ras_n, cas_n, we_n} <= 4'b0010;
                endcase
            end else begin
                {cs_n, ras_n, cas_n, we_n} <= 4'b1111;
            end
        end
    end

endmodule
